wb_port_arbiter: RTL

Shares the single ARF write port between the ALU and LSU result paths. Buffers each source in its own small FIFO and drains them oldest-first, one write per cycle, so same-rd writes keep issue order. Sits between the execute units and the issue stage's register file (`i_wb_*`). Backpressures the sources when a FIFO is full, and can optionally forward buffered, not-yet-written results to issue.

---
 rtl/riscv_uop_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/wb_port_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/riscv_uop_pkg.sv
// Shared write-back types: the buffered result entry and the wrap-safe age compare.
package riscv_uop_pkg;

  // Storage width for age stamps; the arbiter uses only the low STW bits.
  localparam int WB_STW_MAX = 8;

  typedef struct packed {
    logic [4:0]            rd;
    logic [31:0]           data;
    logic [WB_STW_MAX-1:0] stamp;
  } wb_entry_t;

  // a is older than b when (a - b) is negative in stw-bit arithmetic.
  function automatic logic age_older(input logic [WB_STW_MAX-1:0] a,
                                     input logic [WB_STW_MAX-1:0] b,
                                     input int                    stw);
    logic [WB_STW_MAX-1:0] diff;
    diff = (a - b) >> (stw - 1);
    return diff[0];
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO: head view for draining, flat entry view for forwarding.
module wb_fifo
  import riscv_uop_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head,
  output logic [DEPTH-1:0]      ent_vld,
  output wb_entry_t [DEPTH-1:0] ent
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  wb_entry_t [DEPTH-1:0]  mem_q, mem_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign ent   = mem_q;

  // A slot is live when its distance from the read pointer is below occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [AW-1:0] off;
    assign off        = AW'(i) - rd_ptr_q[AW-1:0];
    assign ent_vld[i] = ({1'b0, off} < count);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_entry;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Merges ALU and LSU results onto the single ARF write port, oldest first.
// Optional buffered-result forwarding is compiled in with WB_ARB_FWD_EN.
module wb_port_arbiter
  import riscv_uop_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  output logic        o_alu_ready,
  input  logic        i_lsu_valid,
  input  logic [4:0]  i_lsu_rd,
  input  logic [31:0] i_lsu_data,
  output logic        o_lsu_ready,
  output logic        o_wb_en,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_stall,
  input  logic [4:0]  i_q_rs1,
  input  logic [4:0]  i_q_rs2,
  output logic        o_q_rs1_hit,
  output logic        o_q_rs2_hit,
  output logic [31:0] o_q_rs1_data,
  output logic [31:0] o_q_rs2_data
);

  localparam int STW = $clog2(2*DEPTH) + 1;

  logic [STW-1:0]        stamp_q, stamp_d;
  logic                  alu_store, lsu_store;
  logic                  alu_full, alu_empty, lsu_full, lsu_empty;
  logic                  sel_alu, sel_lsu;
  wb_entry_t             alu_in, lsu_in, alu_head, lsu_head;
  logic [DEPTH-1:0]      alu_vld, lsu_vld;
  wb_entry_t [DEPTH-1:0] alu_ent, lsu_ent;

  assign o_alu_ready = !alu_full;
  assign o_lsu_ready = !lsu_full;
  assign o_stall     = !o_alu_ready || !o_lsu_ready;

  // rd==0 results are consumed from the source but never stored.
  assign alu_store = i_alu_valid && o_alu_ready && (i_alu_rd != 5'd0);
  assign lsu_store = i_lsu_valid && o_lsu_ready && (i_lsu_rd != 5'd0);

  // On a tie the load takes the lower stamp, so it drains first.
  always_comb begin
    alu_in       = '0;
    lsu_in       = '0;
    alu_in.rd    = i_alu_rd;
    alu_in.data  = i_alu_data;
    lsu_in.rd    = i_lsu_rd;
    lsu_in.data  = i_lsu_data;
    lsu_in.stamp = WB_STW_MAX'(stamp_q);
    alu_in.stamp = lsu_store ? WB_STW_MAX'(stamp_q + STW'(1)) : WB_STW_MAX'(stamp_q);
    stamp_d      = stamp_q + STW'(alu_store) + STW'(lsu_store);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stamp_q <= '0;
    else        stamp_q <= stamp_d;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (alu_store),
    .push_entry (alu_in),
    .pop        (sel_alu),
    .full       (alu_full),
    .empty      (alu_empty),
    .head       (alu_head),
    .ent_vld    (alu_vld),
    .ent        (alu_ent)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (lsu_store),
    .push_entry (lsu_in),
    .pop        (sel_lsu),
    .full       (lsu_full),
    .empty      (lsu_empty),
    .head       (lsu_head),
    .ent_vld    (lsu_vld),
    .ent        (lsu_ent)
  );

  always_comb begin
    sel_alu   = !alu_empty &&
                (lsu_empty || age_older(alu_head.stamp, lsu_head.stamp, STW));
    sel_lsu   = !lsu_empty && !sel_alu;
    o_wb_en   = sel_alu || sel_lsu;
    o_wb_rd   = 5'd0;
    o_wb_data = 32'd0;
    if (sel_alu) begin
      o_wb_rd   = alu_head.rd;
      o_wb_data = alu_head.data;
    end else if (sel_lsu) begin
      o_wb_rd   = lsu_head.rd;
      o_wb_data = lsu_head.data;
    end
  end

`ifdef WB_ARB_FWD_EN
  logic [1:0][4:0]            q_rs;
  logic [1:0]                 q_hit;
  logic [1:0][31:0]           q_data;
  logic [1:0][WB_STW_MAX-1:0] q_stamp;

  assign q_rs = {i_q_rs2, i_q_rs1};

  // Youngest matching entry across both FIFOs wins.
  always_comb begin
    q_hit   = '0;
    q_data  = '0;
    q_stamp = '0;
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_vld[i] && (q_rs[q] != 5'd0) && (alu_ent[i].rd == q_rs[q]) &&
            (!q_hit[q] || age_older(q_stamp[q], alu_ent[i].stamp, STW))) begin
          q_hit[q]   = 1'b1;
          q_data[q]  = alu_ent[i].data;
          q_stamp[q] = alu_ent[i].stamp;
        end
        if (lsu_vld[i] && (q_rs[q] != 5'd0) && (lsu_ent[i].rd == q_rs[q]) &&
            (!q_hit[q] || age_older(q_stamp[q], lsu_ent[i].stamp, STW))) begin
          q_hit[q]   = 1'b1;
          q_data[q]  = lsu_ent[i].data;
          q_stamp[q] = lsu_ent[i].stamp;
        end
      end
    end
  end

  assign o_q_rs1_hit  = q_hit[0];
  assign o_q_rs2_hit  = q_hit[1];
  assign o_q_rs1_data = q_data[0];
  assign o_q_rs2_data = q_data[1];
`else
  logic unused_fwd;
  assign unused_fwd   = ^{i_q_rs1, i_q_rs2, alu_vld, alu_ent, lsu_vld, lsu_ent};
  assign o_q_rs1_hit  = 1'b0;
  assign o_q_rs2_hit  = 1'b0;
  assign o_q_rs1_data = 32'd0;
  assign o_q_rs2_data = 32'd0;
`endif

endmodule
